// File: rtl/instr_rom_arbiter.sv
// -----------------------------------------------------------------------------
// instr_rom_arbiter
//
// Shares one combinational-read instruction ROM port between the instruction
// fetch requester (IF) and the load/store requester (LS). It grants at most
// one access per cycle. LS has default priority. IF is forced through after
// MAX_LS_STREAK consecutive LS grants that IF spent waiting. Read data is
// registered, so every granted access returns its response exactly one cycle
// later. Misaligned or out-of-range addresses still complete in one cycle,
// with zero data and the error flag set.
//
// Ports
//   clk        in   1   clock, posedge
//   rst        in   1   asynchronous active-low reset
//   if_req     in   1   fetch request
//   if_addr    in   32  fetch byte address
//   if_gnt     out  1   fetch accepted this cycle (combinational)
//   if_flush   in   1   drop the fetch response presented this cycle
//   if_rvalid  out  1   fetch response valid
//   if_rdata   out  32  fetch data
//   if_err     out  1   fetch error, qualified by if_rvalid
//   ls_req     in   1   load request
//   ls_addr    in   32  load byte address
//   ls_gnt     out  1   load accepted this cycle (combinational)
//   ls_rvalid  out  1   load response valid
//   ls_rdata   out  32  load data
//   ls_err     out  1   load error, qualified by ls_rvalid
//   rom_addr   out  32  byte address to the ROM (0 when nothing is granted)
//   rom_rdata  in   32  ROM read data (combinational)
// -----------------------------------------------------------------------------
module instr_rom_arbiter #(
    parameter int unsigned DEPTH         = 4096,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned MAX_LS_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    input  logic        if_flush,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata
);

    localparam int unsigned           STREAK_W   = $clog2(MAX_LS_STREAK + 1);
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
    localparam logic [STREAK_W-1:0]   STREAK_ONE = STREAK_W'(1);
    localparam logic [31:0]           DEPTH_W    = 32'(DEPTH);

    // Address check. The offset wraps in 32-bit arithmetic, so addresses below
    // the base become huge and fail the range test.
    function automatic logic addr_err_f(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr[1:0] != 2'b00) || ((off >> 2) >= DEPTH_W);
    endfunction

    logic [STREAK_W-1:0] streak_r;
    logic [STREAK_W-1:0] streak_next_s;
    logic                force_if_s;
    logic                if_err_s;
    logic                ls_err_s;
    logic                if_rvalid_r;
    logic                if_err_r;
    logic [31:0]         if_rdata_r;
    logic                ls_rvalid_r;
    logic                ls_err_r;
    logic [31:0]         ls_rdata_r;

    // Arbitration: LS wins unless IF has waited out a full LS streak.
    always_comb begin
        force_if_s = 1'b0;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        if (if_req && (streak_r == STREAK_MAX)) begin
            force_if_s = 1'b1;
        end else begin
            force_if_s = 1'b0;
        end
        if (ls_req && !force_if_s) begin
            ls_gnt = 1'b1;
        end else if (if_req) begin
            if_gnt = 1'b1;
        end else begin
            if_gnt = 1'b0;
            ls_gnt = 1'b0;
        end
    end

    // ROM address mux from the granted requester.
    always_comb begin
        rom_addr = 32'h0000_0000;
        if (if_gnt) begin
            rom_addr = if_addr;
        end else if (ls_gnt) begin
            rom_addr = ls_addr;
        end else begin
            rom_addr = 32'h0000_0000;
        end
    end

    // Streak bookkeeping: counts only LS grants that IF spent waiting.
    always_comb begin
        streak_next_s = streak_r;
        if (!if_req || if_gnt) begin
            streak_next_s = {STREAK_W{1'b0}};
        end else if (ls_gnt && (streak_r < STREAK_MAX)) begin
            streak_next_s = streak_r + STREAK_ONE;
        end else begin
            streak_next_s = streak_r;
        end
    end

    // Error flags for the addresses currently on the request ports.
    always_comb begin
        if_err_s = addr_err_f(if_addr);
        ls_err_s = addr_err_f(ls_addr);
    end

    // Response pipeline and streak register; rdata holds when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_r    <= {STREAK_W{1'b0}};
            if_rvalid_r <= 1'b0;
            if_err_r    <= 1'b0;
            if_rdata_r  <= 32'h0000_0000;
            ls_rvalid_r <= 1'b0;
            ls_err_r    <= 1'b0;
            ls_rdata_r  <= 32'h0000_0000;
        end else begin
            streak_r    <= streak_next_s;
            if_rvalid_r <= if_gnt;
            if_err_r    <= if_gnt && if_err_s;
            ls_rvalid_r <= ls_gnt;
            ls_err_r    <= ls_gnt && ls_err_s;
            if (if_gnt) begin
                if_rdata_r <= if_err_s ? 32'h0000_0000 : rom_rdata;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if (ls_gnt) begin
                ls_rdata_r <= ls_err_s ? 32'h0000_0000 : rom_rdata;
            end else begin
                ls_rdata_r <= ls_rdata_r;
            end
        end
    end

    // A flush arriving with the fetch response suppresses it in that same cycle.
    always_comb begin
        if_rvalid = if_rvalid_r && !if_flush;
        if_err    = if_err_r && !if_flush;
        if_rdata  = if_rdata_r;
        ls_rvalid = ls_rvalid_r;
        ls_err    = ls_err_r;
        ls_rdata  = ls_rdata_r;
    end

endmodule

// File: tb/tb_instr_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_instr_rom_arbiter
//
// Drives IF/LS requests once per cycle, predicts grants from a simple
// arbitration model, and pushes the predicted response for the following cycle
// into a scoreboard queue. A monitor process pops and compares the responses.
// The ROM is modelled as a randomly filled array that is read combinationally.
// -----------------------------------------------------------------------------
module tb_instr_rom_arbiter;

    localparam int DEPTH = 4096;
    localparam int MAXS  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, if_flush;
    logic [31:0] if_addr, ls_addr;
    logic        if_gnt, ls_gnt;
    logic        if_rvalid, ls_rvalid, if_err, ls_err;
    logic [31:0] if_rdata, ls_rdata, rom_addr, rom_rdata;

    logic [31:0] rom_mem [DEPTH];

    always #5 clk = ~clk;

    instr_rom_arbiter #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .MAX_LS_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_flush(if_flush),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata)
    );

    // Out-of-range reads return a recognisable junk pattern, which the DUT must not pass on.
    always_comb begin
        if (rom_addr[31:14] == 18'd0) rom_rdata = rom_mem[rom_addr[13:2]];
        else                          rom_rdata = 32'hBAD0_BAD0;
    end

    typedef struct {
        int          cyc;
        logic        if_v;
        logic        if_e;
        logic [31:0] if_d;
        bit          if_known;
        logic        ls_v;
        logic        ls_e;
        logic [31:0] ls_d;
        bit          ls_known;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          in_reset = 1'b1;
    int          ls_run   = 0;
    bit          flush_plan = 1'b0;
    logic [31:0] last_if_d = 32'h0;
    logic [31:0] last_ls_d = 32'h0;
    bit          if_known = 1'b1;
    bit          ls_known = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        logic [31:0] word;
        word = (a - 32'h0) / 32'd4;
        return (a % 32'd4 != 32'd0) || (word >= 32'(DEPTH));
    endfunction

    function automatic exp_t idle_exp(input int c);
        exp_t e;
        e.cyc = c; e.if_v = 1'b0; e.if_e = 1'b0; e.if_d = 32'h0; e.if_known = 1'b1;
        e.ls_v = 1'b0; e.ls_e = 1'b0; e.ls_d = 32'h0; e.ls_known = 1'b1;
        return e;
    endfunction

    // One request cycle: drive, check grants, predict the next-cycle response.
    task automatic do_cycle(input bit ir, input logic [31:0] ia, input bit lr,
                            input logic [31:0] la, input bit flush_next,
                            output bit gi, output bit gl);
        exp_t e;
        bit   bad;
        @(negedge clk);
        cyc++;
        if_req = ir; if_addr = ia; ls_req = lr; ls_addr = la;
        if_flush = flush_plan;
        flush_plan = flush_next;
        // IF has waited through a full streak of LS grants -> IF goes first.
        if (ir && ls_run == MAXS) begin gi = 1'b1; gl = 1'b0; end
        else if (lr)              begin gi = 1'b0; gl = 1'b1; end
        else                      begin gi = ir;   gl = 1'b0; end
        #1;
        check("if_gnt", 32'(if_gnt), 32'(gi));
        check("ls_gnt", 32'(ls_gnt), 32'(gl));
        check("rom_addr", rom_addr, gi ? ia : (gl ? la : 32'h0));
        e = idle_exp(cyc + 1);
        if (gi) begin
            bad = bad_addr(ia);
            if (flush_next) begin
                if_known = 1'b0;
            end else begin
                e.if_v = 1'b1; e.if_e = bad;
                last_if_d = bad ? 32'h0 : rom_mem[ia[13:2]];
                if_known = 1'b1;
            end
        end
        if (gl) begin
            bad = bad_addr(la);
            e.ls_v = 1'b1; e.ls_e = bad;
            last_ls_d = bad ? 32'h0 : rom_mem[la[13:2]];
            ls_known = 1'b1;
        end
        e.if_d = last_if_d; e.if_known = if_known;
        e.ls_d = last_ls_d; e.ls_known = ls_known;
        sb.push_back(e);
        if (!ir || gi)    ls_run = 0;
        else if (ls_run < MAXS) ls_run = ls_run + 1;
    endtask

    // Monitor: compares DUT responses against the queued predictions for this cycle.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!in_reset && sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("if_rvalid", 32'(if_rvalid), 32'(e.if_v));
            check("if_err", 32'(if_err), 32'(e.if_e));
            if (e.if_v || e.if_known) check("if_rdata", if_rdata, e.if_d);
            check("ls_rvalid", 32'(ls_rvalid), 32'(e.ls_v));
            check("ls_err", 32'(ls_err), 32'(e.ls_e));
            if (e.ls_v || e.ls_known) check("ls_rdata", ls_rdata, e.ls_d);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          gi, gl, ir, lr, fl;
        logic [9:0]  pat;
        logic [31:0] ia, la;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
        if_addr = 32'h0; ls_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_rvalid", 32'(if_rvalid), 32'h0);
        check("rst_ls_rvalid", 32'(ls_rvalid), 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        check("rst_err", 32'({if_err, ls_err}), 32'h0);
        check("rst_rom_addr", rom_addr, 32'h0);
        @(posedge clk); #3; rst = 1'b1; in_reset = 1'b0;
        sb.push_back(idle_exp(cyc + 1));

        // IF-only stream from address 0
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'(4 * i), 1'b0, 32'h0, 1'b0, gi, gl);
        // idle: nothing granted, data retained
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);

        // both requesting for 10 cycles: LLLLI LLLLI
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b1, 32'(32'h40 + 4 * i), 1'b1, 32'(32'h100 + 4 * i), 1'b0, gi, gl);
            pat[i] = gi;
        end
        check("streak_pattern", 32'(pat), 32'(10'b10000_10000));
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);

        // LS errors: misaligned, then out of range
        do_cycle(1'b0, 32'h0, 1'b1, 32'h0000_0002, 1'b0, gi, gl);
        do_cycle(1'b0, 32'h0, 1'b1, 32'h0000_4000, 1'b0, gi, gl);
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);

        // flush of the fetch to 0x10; fetch granted during the flush is kept
        do_cycle(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, gi, gl);
        do_cycle(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, gi, gl);
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);

        // reset while a response is pending
        do_cycle(1'b1, 32'h20, 1'b1, 32'h24, 1'b0, gi, gl);
        do_cycle(1'b1, 32'h28, 1'b1, 32'h2C, 1'b0, gi, gl);
        #3;
        in_reset = 1'b1; rst = 1'b0;
        #1;
        check("async_rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'h0);
        check("async_rst_err", 32'({if_err, ls_err}), 32'h0);
        check("async_rst_if_rdata", if_rdata, 32'h0);
        check("async_rst_ls_rdata", ls_rdata, 32'h0);
        sb.delete();
        ls_run = 0; flush_plan = 1'b0;
        last_if_d = 32'h0; last_ls_d = 32'h0; if_known = 1'b1; ls_known = 1'b1;
        @(posedge clk); #1;
        check("rst_pending_lost", 32'({if_rvalid, ls_rvalid}), 32'h0);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1; in_reset = 1'b0;
        sb.push_back(idle_exp(cyc + 1));
        do_cycle(1'b1, 32'h30, 1'b1, 32'h34, 1'b0, gi, gl);
        check("post_rst_ls_first", 32'(ls_gnt), 32'h1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int k;
            ir = ($urandom_range(0, 3) != 0);
            lr = ($urandom_range(0, 1) != 0);
            fl = ($urandom_range(0, 5) == 0);
            k = $urandom_range(0, 9);
            if (k < 8)       ia = 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (k == 8) ia = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else             ia = 32'h4000 + 32'(4 * $urandom_range(0, 1000));
            k = $urandom_range(0, 9);
            if (k < 8)       la = 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (k == 8) la = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else             la = 32'hFFFF_FFFC;
            do_cycle(ir, ia, lr, la, fl, gi, gl);
        end
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);
        do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, gi, gl);
        @(negedge clk);
        cyc++;
        if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
